// File: rtl/vga_framebuffer.sv
// ---------------------------------------------------------------------------
// vga_framebuffer
//
// Pixel source for the VGA timing driver. Stores a 160x120 RRRGGGBB image and
// presents it upscaled 4x to 640x480. The driver addresses it with next_x /
// next_y, and color_out returns one clock later. Game logic writes pixels into
// the back page. A clear engine fills the back page one address per cycle. A
// page flip is synchronised to the falling edge of vsync.
//
// Build option:
//   VGA_FB_DOUBLE_BUFFER_EN defined   : two pages, and the flip swaps front and back.
//   VGA_FB_DOUBLE_BUFFER_EN undefined : a single page. front_page is tied to 0,
//                                       and the swap handshake still runs.
//
// Ports:
//   clock, reset          25 MHz pixel clock. Synchronous active-high reset.
//   next_x, next_y        Screen coordinate of the next pixel.
//   vsync                 Driver vsync, an active-low pulse.
//   color_out             Registered pixel colour, with one cycle of latency.
//   wr_en/wr_x/wr_y/wr_color, wr_ready
//                         Pixel write into the back page. Accepted only when idle.
//   clear_req, clear_color, busy
//                         Back-page fill engine.
//   swap_req, swap_pending, swap_done, front_page
//                         Page flip handshake.
// ---------------------------------------------------------------------------
module vga_framebuffer #(
    parameter int FB_W          = 160,
    parameter int FB_H          = 120,
    parameter int SCALE_SHIFT   = 2,
    parameter int CLEAR_COLOR_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [9:0]               next_x,
    input  logic [9:0]               next_y,
    input  logic                     vsync,
    output logic [7:0]               color_out,
    input  logic                     wr_en,
    input  logic [7:0]               wr_x,
    input  logic [6:0]               wr_y,
    input  logic [7:0]               wr_color,
    output logic                     wr_ready,
    input  logic                     clear_req,
    input  logic [CLEAR_COLOR_W-1:0] clear_color,
    output logic                     busy,
    input  logic                     swap_req,
    output logic                     swap_pending,
    output logic                     swap_done,
    output logic                     front_page
);

    localparam int FB_SIZE = FB_W * FB_H;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
    localparam int PAGES = 2;
`else
    localparam int PAGES = 1;
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [15:0]              clr_cnt;
    logic [15:0]              clr_cnt_next;
    logic [CLEAR_COLOR_W-1:0] fill;
    logic [CLEAR_COLOR_W-1:0] fill_next;

    logic                     mem_we;
    logic [15:0]              mem_waddr;
    logic [7:0]               mem_wdata;
    logic [7:0]               mem [0:PAGES*FB_SIZE-1];

    logic                     rd_page;
    logic                     wr_page;
    logic [15:0]              rd_base;
    logic [15:0]              wr_base;

    logic [9:0]               rd_sx;
    logic [9:0]               rd_sy;
    logic                     rd_in_range;
    logic [15:0]              rd_addr;
    logic                     wr_in_range;
    logic [15:0]              wr_addr;

    logic                     vsync_cur;
    logic                     vsync_prev;
    logic                     vsync_fall;
    logic                     flip;

    // ---------------- page selection ----------------
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic front;

    // Front page register. It toggles only when a flip is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            front <= 1'b0;
        end else if (flip) begin
            front <= ~front;
        end
    end

    assign front_page = front;
    assign rd_page    = front;
    assign wr_page    = ~front;
`else
    assign front_page = 1'b0;
    assign rd_page    = 1'b0;
    assign wr_page    = 1'b0;
`endif

    assign rd_base = rd_page ? 16'(FB_SIZE) : 16'd0;
    assign wr_base = wr_page ? 16'(FB_SIZE) : 16'd0;

    // ---------------- address generation ----------------
    // The screen coordinate is downscaled to the framebuffer coordinate. All 10
    // bits are kept so that screen coordinates past 639/479 still fall out of range.
    assign rd_sx       = next_x >> SCALE_SHIFT;
    assign rd_sy       = next_y >> SCALE_SHIFT;
    assign rd_in_range = (rd_sx < 10'(FB_W)) && (rd_sy < 10'(FB_H));
    assign rd_addr     = rd_base + 16'(rd_sy) * 16'(FB_W) + 16'(rd_sx);

    assign wr_in_range = (8'(wr_x) < 8'(FB_W)) && (7'(wr_y) < 7'(FB_H));
    assign wr_addr     = wr_base + 16'(wr_y) * 16'(FB_W) + 16'(wr_x);

    // ---------------- clear FSM ----------------
    // Clear FSM state register, with the address counter and the latched fill colour.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= 16'd0;
            fill    <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            fill    <= fill_next;
        end
    end

    // Next-state logic and the single memory write port. The write port is shared
    // by pixel writes (only in IDLE) and clear writes (only in CLEAR).
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        fill_next    = fill;
        mem_we       = 1'b0;
        mem_waddr    = 16'd0;
        mem_wdata    = 8'h00;
        case (state)
            IDLE: begin
                if (wr_en && wr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
                    mem_wdata = wr_color;
                end else begin
                    mem_we    = 1'b0;
                end
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = 16'd0;
                    fill_next    = clear_color;
                end else begin
                    state_next   = IDLE;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = wr_base + clr_cnt;
                mem_wdata = 8'(fill);
                if (clr_cnt == 16'(FB_SIZE - 1)) begin
                    state_next = IDLE;
                end else begin
                    clr_cnt_next = clr_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign wr_ready = (state == IDLE);

    // ---------------- storage ----------------
    // Pixel memory write port. The contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port. An out-of-range coordinate reads as black.
    always_ff @(posedge clock) begin
        if (reset) begin
            color_out <= 8'h00;
        end else if (rd_in_range) begin
            color_out <= mem[rd_addr];
        end else begin
            color_out <= 8'h00;
        end
    end

    // ---------------- vsync-synchronised swap ----------------
    assign vsync_fall = vsync_prev && !vsync_cur;
    // A flip waits for an idle FSM, so a clear never straddles a page change.
    assign flip       = vsync_fall && swap_pending && (state == IDLE);

    // vsync edge detector, pending flag and swap_done pulse. The idle level of vsync
    // is high, so the detector resets high and no edge is seen at start-up.
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_cur    <= 1'b1;
            vsync_prev   <= 1'b1;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            vsync_cur    <= vsync;
            vsync_prev   <= vsync_cur;
            swap_done    <= flip;
            if (flip) begin
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_framebuffer.sv
// ---------------------------------------------------------------------------
// Testbench for vga_framebuffer. Directed stimulus is applied. Read expectations
// are pushed into a queue, and a monitor compares them when the delayed read
// strobe arrives. Control signals are checked directly against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_vga_framebuffer;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       vsync;
    logic [7:0] color_out;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic [7:0] wr_color;
    logic       wr_ready;
    logic       clear_req;
    logic [7:0] clear_color;
    logic       busy;
    logic       swap_req;
    logic       swap_pending;
    logic       swap_done;
    logic       front_page;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic       exp_front = 1'b0;

    logic       rd_valid   = 1'b0;
    logic       rd_valid_d = 1'b0;
    logic [7:0] exp_q[$];

    vga_framebuffer dut (
        .clock        (clock),
        .reset        (reset),
        .next_x       (next_x),
        .next_y       (next_y),
        .vsync        (vsync),
        .color_out    (color_out),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_color     (wr_color),
        .wr_ready     (wr_ready),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .busy         (busy),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .front_page   (front_page)
    );

    always #20 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The read strobe is delayed by one cycle to line up with color_out.
    always @(posedge clock) rd_valid_d <= rd_valid;

    // Monitor: pops one expected colour per presented read.
    always @(negedge clock) begin
        if (rd_valid_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL read_unexpected: got %0h expected none", color_out);
            end else begin
                chk("read_color", {24'd0, color_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int x, input int y, input logic [7:0] e);
        next_x   = 10'(x);
        next_y   = 10'(y);
        rd_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input logic [7:0] c);
        wr_en    = 1'b1;
        wr_x     = 8'(x);
        wr_y     = 7'(y);
        wr_color = c;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Drives one vsync low pulse and counts the swap_done pulses around it.
    task automatic do_vsync(output int pulses);
        pulses = 0;
        vsync  = 1'b0;
        repeat (6) begin
            tick();
            if (swap_done) pulses++;
        end
        vsync = 1'b1;
        repeat (3) begin
            tick();
            if (swap_done) pulses++;
        end
    endtask

    task automatic expect_flip();
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        exp_front = ~exp_front;
`endif
    endtask

    initial begin
        int   p;
        int   cyc;
        logic ready_bad;
        logic done_seen;

        reset = 1'b1; vsync = 1'b1; next_x = 10'd0; next_y = 10'd0;
        wr_en = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_color = 8'h00;
        clear_req = 1'b0; clear_color = 8'h00; swap_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_color_out", {24'd0, color_out}, 32'h0);
        chk("rst_front", {31'd0, front_page}, 32'd0);
        chk("rst_pending", {31'd0, swap_pending}, 32'd0);
        chk("rst_done", {31'd0, swap_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Pixel writes, including out-of-range ones that must be dropped
        wr(5, 7, 8'hE0);
        wr(0, 1, 8'h11);
        wr(0, 0, 8'h22);
        wr(160, 0, 8'hFF);
        chk("oor_x_wr_ready", {31'd0, wr_ready}, 32'd1);
        wr(0, 120, 8'hFF);
        chk("oor_y_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Swap requested mid-frame, then serviced at the vsync fall
        pulse_swap();
        chk("swap_pending_set", {31'd0, swap_pending}, 32'd1);
        repeat (10) tick();
        chk("swap_pending_hold", {31'd0, swap_pending}, 32'd1);
        do_vsync(p);
        expect_flip();
        chk("swap1_pulses", p, 32'd1);
        chk("swap1_front", {31'd0, front_page}, {31'd0, exp_front});
        chk("swap1_pending", {31'd0, swap_pending}, 32'd0);

        // The 4x4 screen block of fb(5,7), then the dropped writes and the boundaries
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                rd(20 + dx, 28 + dy, 8'hE0);
        rd(3, 7, 8'h11);
        rd(0, 0, 8'h22);
        rd(640, 0, 8'h00);
        rd(0, 480, 8'h00);
        rd(1023, 1023, 8'h00);
        repeat (2) tick();

        // Clear with 1C. This covers a swap during the clear, a vsync edge during
        // the clear, a second clear_req and a dropped write.
        clear_color = 8'h1C;
        clear_req   = 1'b1;
        tick();
        clear_req   = 1'b0;
        clear_color = 8'h00;
        chk("clear_busy_start", {31'd0, busy}, 32'd1);
        cyc = 0; ready_bad = 1'b0; done_seen = 1'b0;
        while (busy && cyc < 20000) begin
            cyc++;
            if (wr_ready) ready_bad = 1'b1;
            if (swap_done) done_seen = 1'b1;
            swap_req    = (cyc == 100);
            vsync       = !(cyc >= 200 && cyc < 300);
            clear_req   = (cyc == 500);
            clear_color = (cyc == 500) ? 8'h99 : 8'h00;
            wr_en       = (cyc == 19190);
            wr_x        = 8'd0;
            wr_y        = 7'd0;
            wr_color    = 8'h55;
            tick();
        end
        swap_req = 1'b0; vsync = 1'b1; clear_req = 1'b0; wr_en = 1'b0;
        chk("clear_busy_cycles", cyc, 32'd19200);
        chk("clear_wr_ready_low", {31'd0, ready_bad}, 32'd0);
        chk("clear_no_flip", {31'd0, done_seen}, 32'd0);
        chk("clear_pending_kept", {31'd0, swap_pending}, 32'd1);
        chk("clear_end_wr_ready", {31'd0, wr_ready}, 32'd1);

        // The deferred flip happens at the first vsync edge after the clear
        do_vsync(p);
        expect_flip();
        chk("swap2_pulses", p, 32'd1);
        chk("swap2_front", {31'd0, front_page}, {31'd0, exp_front});
        chk("swap2_pending", {31'd0, swap_pending}, 32'd0);
        rd(0, 0, 8'h1C);
        rd(639, 479, 8'h1C);
        rd(636, 0, 8'h1C);
        rd(0, 476, 8'h1C);
        rd(20, 28, 8'h1C);
        rd(320, 240, 8'h1C);
        for (int x = 0; x < 160; x++) rd(x * 4, 200, 8'h1C);
        repeat (2) tick();

        // Three requests within one frame give a single flip
        for (int i = 0; i < 3; i++) begin
            pulse_swap();
            repeat (5) tick();
        end
        chk("coalesce_pending", {31'd0, swap_pending}, 32'd1);
        do_vsync(p);
        expect_flip();
        chk("coalesce_pulses", p, 32'd1);
        chk("coalesce_front", {31'd0, front_page}, {31'd0, exp_front});
        do_vsync(p);
        chk("no_req_pulses", p, 32'd0);
        chk("no_req_front", {31'd0, front_page}, {31'd0, exp_front});

        // Reset in the middle of a clear, with a swap pending
        clear_color = 8'h1C;
        clear_req   = 1'b1;
        tick();
        clear_req   = 1'b0;
        repeat (50) tick();
        pulse_swap();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_pending", {31'd0, swap_pending}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_front = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pending", {31'd0, swap_pending}, 32'd0);
        chk("mid_rst_front", {31'd0, front_page}, {31'd0, exp_front});
        chk("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("reclear_busy", {31'd0, busy}, 32'd1);
        chk("reclear_wr_ready", {31'd0, wr_ready}, 32'd0);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Pixel source directly upstream of the VGA timing driver. It holds a 160×120 RRRGGGBB image, upscaled 4× to 640×480. It is addressed by the driver's `next_x`/`next_y` and returns `color_out`, which feeds the driver's `color_in`. Game logic writes pixels into a back page. A clear engine and a vsync-synchronised page flip provide tear-free frames.

## Interface
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in pixels.
- `SCALE_SHIFT`, 2: screen-to-framebuffer shift, so fb coordinate = screen coordinate >> 2.
- `CLEAR_COLOR_W`, 8: width of `clear_color`. Fixed to 8.

Ports:
- `clock` in 1: 25 MHz pixel clock, same clock as the VGA driver.
- `reset` in 1: reset, synchronous, active-high; clock clock.
- `next_x` in 10: screen x of the next pixel, from the driver.
- `next_y` in 10: screen y of the next pixel, from the driver.
- `vsync` in 1: driver vsync, active-low pulse.
- `color_out` out 8: pixel colour for the driver's `color_in`.
- `wr_en` in 1: pixel write strobe, into the back page.
- `wr_x` in 8: write x coordinate.
- `wr_y` in 7: write y coordinate.
- `wr_color` in 8: write data.
- `wr_ready` out 1: high when writes are accepted.
- `clear_req` in 1: one-cycle pulse that starts a back-page clear.
- `clear_color` in 8: fill colour, sampled on the `clear_req` cycle.
- `busy` out 1: high while a clear is running.
- `swap_req` in 1: one-cycle pulse requesting a page flip.
- `swap_pending` out 1: flip requested but not yet performed.
- `swap_done` out 1: one-cycle pulse on the cycle the flip takes effect.
- `front_page` out 1: index of the page currently displayed.

## Operation
- Storage: two pages of FB_W×FB_H bytes. Address = y*FB_W + x, range 0..19199. Memory contents are not reset.
- Read path:
  - fb_x = `next_x` >> SCALE_SHIFT; fb_y = `next_y` >> SCALE_SHIFT.
  - Reads come from page `front_page`.
  - fb coordinates with fb_x ≥ FB_W or fb_y ≥ FB_H read as 8'h00.
- Write path:
  - When `wr_en` && `wr_ready`, write `wr_color` at (`wr_x`,`wr_y`) in page !`front_page`.
  - Out-of-range coordinates (wr_x ≥ FB_W or wr_y ≥ FB_H) are silently dropped.
  - `wr_en` while `wr_ready`=0 is dropped; there is no queuing.
- Clear FSM:
  - States: IDLE → CLEAR → IDLE.
  - IDLE: `clear_req` → latch `clear_color`, set address counter to 0, go to CLEAR.
  - CLEAR: write the fill colour to the back page at the counter address, one address per cycle, ascending. When the counter reaches FB_W*FB_H−1, write that final address, then return to IDLE.
  - The clear occupies exactly 19200 cycles in CLEAR.
  - `busy` = (state==CLEAR). `wr_ready` = (state==IDLE).
  - `clear_req` while in CLEAR is ignored.
- Swap:
  - `swap_req` sets `swap_pending`. Repeat requests while pending coalesce into a single flip.
  - `vsync` is registered once; a falling edge is detected as (prev==1 && cur==0).
  - On a detected falling edge with `swap_pending`=1 and state==IDLE: toggle `front_page`, clear `swap_pending`, pulse `swap_done`.
  - If a clear is running at the edge, the flip defers to the next vsync edge that finds the FSM in IDLE.

## Timing
- Reset values: `color_out`=0, `front_page`=0, `swap_pending`=0, `swap_done`=0, `busy`=0, state IDLE, so `wr_ready`=1 on the first cycle after reset deasserts.
- Read latency is 1 cycle: `color_out` at edge n+1 reflects `next_x`/`next_y`/`front_page` as sampled at edge n.
- A write is visible to a read of the same page one cycle after the write edge. Reads of the back page are never issued.
- `clear_req` at edge n puts the FSM in CLEAR from edge n+1. `busy` falls at edge n+19201.
- `wr_en` and `clear_req` on the same cycle: the write is performed and the clear starts on the next cycle.
- `swap_req` on the same cycle as a detected vsync edge is not serviced at that edge; it is serviced at the next frame.
- `swap_done` is asserted for one cycle, coincident with the cycle `front_page` first shows its new value.
- Reset mid-clear aborts the clear immediately. Reset mid-pending drops the request.

## Configuration
- `VGA_FB_DOUBLE_BUFFER_EN` defined: two pages, behaviour as above.
- `VGA_FB_DOUBLE_BUFFER_EN` undefined:
  - Single page; reads, writes and clears all target page 0.
  - `front_page` is tied to 0.
  - `swap_req` still sets `swap_pending`, and the vsync edge still clears it and pulses `swap_done`, with no page change. This keeps the software handshake identical.

## Test plan
- Reset, then write (5,7)=8'hE0. Drive next_x=20..23 and next_y=28..31 after a swap: `color_out`=8'hE0 one cycle later for all 16 screen pixels; neighbouring pixel (24,28) reads 8'h00 or its prior value.
- Write (160,0)=8'hFF and (0,120)=8'hFF: no memory change; `wr_ready` stays 1.
- `clear_req` with `clear_color`=8'h1C: `busy` high for exactly 19200 cycles and `wr_ready`=0 meanwhile. After a swap, every read returns 8'h1C.
- `swap_req` mid-frame: `swap_pending`=1 until the next vsync falling edge, then `front_page` toggles with a single `swap_done` pulse. Three requests within one frame give one flip.
- `swap_req` issued during a clear spanning a vsync edge: no flip at that edge; flip at the first edge after `busy` falls.
- Assert reset for 1 cycle mid-clear: `busy`=0 and `swap_pending`=0 next cycle, `front_page`=0, and a new `clear_req` is accepted.
